axi_lite_apb_bridge: RTL and testbench
======================================

// Module: axi_lite_apb_bridge
// PURPOSE
//  Single-slave AXI4-Lite to APB bridge; APB side drives the testbench UART/peripheral port directly.
//  Buffers one AW, one W and one AR beat and runs one APB transfer at a time.
//  Returns the result on B/R and enforces a pready timeout so a hung slave cannot stall the bus.
// PARAMETERS
//  AXI_ADDR_WIDTH  64   AXI address width; paddr_o = addr[31:0]
//  TIMEOUT_CYCLES  256  max ACCESS cycles before forced SLVERR; 0 disables timeout
// PORTS
//  clk_i        in   1   clock
//  rst_ni       in   1   reset, synchronous active-low
//  awaddr_i     in   AW  write address        | awvalid_i in 1 | awready_o out 1
//  wdata_i      in   32  write data           | wstrb_i in 4 | wvalid_i in 1 | wready_o out 1
//  bresp_o      out  2   write response       | bvalid_o out 1 | bready_i in 1
//  araddr_i     in   AW  read address         | arvalid_i in 1 | arready_o out 1
//  rdata_o      out  32  read data            | rresp_o out 2 | rvalid_o out 1 | rready_i in 1
//  psel_o       out  1   APB select
//  penable_o    out  1   APB enable
//  pwrite_o     out  1   APB direction, 1=write
//  paddr_o      out  32  APB address
//  pwdata_o     out  32  APB write data
//  pstrb_o      out  4   APB4 strobe (copy of wstrb)
//  prdata_i     in   32  APB read data
//  pready_i     in   1   APB ready
//  pslverr_i    in   1   APB error
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): all holding regs invalid, FSM=IDLE, rr_last=READ;
//   every output 0 (psel, penable, all *valid, *ready, paddr, pwdata, pstrb, rdata, resp).
//   Reset mid-transfer abandons it: no B/R response is produced.
//  Capture: awready_o=~aw_q_vld, wready_o=~w_q_vld, arready_o=~ar_q_vld, all registered,
//   deasserted in reset; handshake on valid&ready loads addr/data/strb and sets the vld flag.
//   AW and W are independent; a write is pending only when aw_q_vld & w_q_vld.
//  FSM states: IDLE, SETUP, ACCESS, RESP.
//   IDLE:   pending write and/or read -> SETUP; if both pending, grant opposite of rr_last
//           (write wins the first tie after reset); grant sets rr_last and latches
//           pwrite/paddr/pwdata/pstrb.
//   SETUP:  psel=1 penable=0, exactly one cycle -> ACCESS.
//   ACCESS: psel=1 penable=1; counter starts at 0 on entry.
//           pready_i=1: capture prdata_i and pslverr_i; resp=SLVERR(2'b10) if pslverr_i else OKAY(2'b00).
//           Counter reaches TIMEOUT_CYCLES-1 with no pready: resp=SLVERR, rdata=32'hDEAD_BEEF.
//           Either completion -> RESP; psel/penable drop the cycle after completion.
//   RESP:   write: bvalid_o=1 held until bready_i; read: rvalid_o=1 held until rready_i.
//           On handshake clear the consumed holding flags (aw+w, or ar) -> IDLE.
//  Read data, resp and paddr/pwdata stay stable while valid is held.
//  Latency, pready=1 at first ACCESS: handshake cycle N -> SETUP N+2 -> ACCESS N+3 -> b/rvalid N+4.
//  Flags clear at the response handshake, so the next AW/W/AR capture opens 1 cycle later.
//   Beats arriving during a transfer are captured if their slot is free.
//  pwrite_o/paddr_o/pwdata_o change only when entering SETUP; psel_o never glitches between transfers.
//  AxPROT is ignored; wstrb=0 still issues an APB write with pstrb_o=0.
// TESTING
//  1 Write 0x0000_0041 to 0x1000_0000, pready=1 -> one SETUP+ACCESS, paddr=0x1000_0000,
//    pwrite=1, pwdata=0x41, bresp=00, bvalid at N+4.
//  2 Read 0x1000_0014, prdata=0x60 -> pwrite=0, rdata=0x60, rresp=00.
//  3 AW, W and AR same cycle, all ready high -> write first, then read; a second tie is granted read first.
//  4 Write with pslverr=1 after 3 wait states -> ACCESS lasts 4 cycles, bresp=10.
//  5 TIMEOUT_CYCLES=8, pready held 0 -> penable high exactly 8 cycles, rresp=10, rdata=DEADBEEF.
//  6 bready low 5 cycles -> bvalid/bresp stable, no new APB transfer; assert rst_ni=0 during
//    ACCESS -> next cycle psel=0, all valids 0, and no response ever appears.

Source files
------------

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite to APB4 bridge for a single slave.
// One buffered AW/W/AR beat each, one APB transfer in flight, pready timeout.
module axi_lite_apb_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    output logic [31:0]               rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [31:0]               paddr_o,
    output logic [31:0]               pwdata_o,
    output logic [3:0]                pstrb_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_e state_q, state_d;

    logic        aw_vld_q, aw_vld_d;
    logic        w_vld_q, w_vld_d;
    logic        ar_vld_q, ar_vld_d;
    logic        awready_q, wready_q, arready_q;
    logic [31:0] aw_addr_q, ar_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        rr_wr_q;
    logic        pwrite_q;
    logic [31:0] paddr_q, pwdata_q;
    logic [3:0]  pstrb_q;
    logic [CW-1:0] cnt_q;

    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    logic aw_hs, w_hs, ar_hs;
    logic wr_pend, rd_pend, grant_wr;
    logic grant, done, resp_hs, timeout_hit;
    logic [1:0] resp_d;

    assign aw_hs = awvalid_i & awready_q;
    assign w_hs  = wvalid_i & wready_q;
    assign ar_hs = arvalid_i & arready_q;

    assign wr_pend = aw_vld_q & w_vld_q;
    assign rd_pend = ar_vld_q;
    // On a tie, grant the direction that did not win last time.
    assign grant_wr = wr_pend & (~rd_pend | ~rr_wr_q);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign resp_hs = (state_q == RESP) &
                     (pwrite_q ? bready_i : rready_i);
    assign resp_d = (pready_i && !pslverr_i) ? RESP_OKAY : RESP_SLVERR;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_pend || rd_pend) begin
                    state_d = SETUP;
                    grant   = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_i || timeout_hit) begin
                    state_d = RESP;
                    done    = 1'b1;
                end
            end
            RESP: begin
                if (resp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aw_vld_d = aw_vld_q;
        w_vld_d  = w_vld_q;
        ar_vld_d = ar_vld_q;
        if (aw_hs) aw_vld_d = 1'b1;
        if (w_hs)  w_vld_d  = 1'b1;
        if (ar_hs) ar_vld_d = 1'b1;
        if (resp_hs && pwrite_q) begin
            aw_vld_d = 1'b0;
            w_vld_d  = 1'b0;
        end
        if (resp_hs && !pwrite_q) ar_vld_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_vld_q  <= 1'b0;
            w_vld_q   <= 1'b0;
            ar_vld_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rr_wr_q   <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            cnt_q     <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_vld_q  <= aw_vld_d;
            w_vld_q   <= w_vld_d;
            ar_vld_q  <= ar_vld_d;
            awready_q <= ~aw_vld_d;
            wready_q  <= ~w_vld_d;
            arready_q <= ~ar_vld_d;
            if (aw_hs) aw_addr_q <= awaddr_i[31:0];
            if (ar_hs) ar_addr_q <= araddr_i[31:0];
            if (w_hs) begin
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
            if (grant) begin
                rr_wr_q  <= grant_wr;
                pwrite_q <= grant_wr;
                paddr_q  <= grant_wr ? aw_addr_q : ar_addr_q;
                pwdata_q <= grant_wr ? w_data_q : '0;
                pstrb_q  <= grant_wr ? w_strb_q : '0;
            end
            cnt_q <= (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
            if (done) begin
                if (pwrite_q) begin
                    bresp_q <= resp_d;
                end else begin
                    rresp_q <= resp_d;
                    rdata_q <= pready_i ? prdata_i : TIMEOUT_DATA;
                end
            end
        end
    end

    if (AXI_ADDR_WIDTH > 32) begin : g_hi_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^{awaddr_i[AXI_ADDR_WIDTH-1:32],
                                  araddr_i[AXI_ADDR_WIDTH-1:32]};
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign arready_o = arready_q;

    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;

    assign bvalid_o = (state_q == RESP) && pwrite_q;
    assign rvalid_o = (state_q == RESP) && !pwrite_q;
    assign bresp_o  = bresp_q;
    assign rresp_o  = rresp_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Scoreboard bench for axi_lite_apb_bridge: random AXI traffic,
// APB slave model with scripted waits/errors/hangs, queued expectations.
module tb_axi_lite_apb_bridge;

    localparam int TO = 8;

    typedef struct packed {
        logic [3:0]  waits;
        logic        err;
        logic        hang;
        logic [31:0] data;
    } beh_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } apbw_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, arvalid, arready;
    logic [31:0] wdata, rdata, prdata, paddr, pwdata;
    logic [3:0]  wstrb, pstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, rvalid, rready;
    logic        psel, penable, pwrite, pready, pslverr;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [63:0] aw_stim[$];
    logic [35:0] w_stim[$];
    logic [63:0] ar_stim[$];
    apbw_t       exp_apw[$];
    logic [31:0] exp_apr[$];
    beh_t        wbeh[$], rbeh[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic        dir_log[$];

    bit no_gap = 1'b1;
    bit hold_b = 1'b0;
    bit aw_fire, w_fire, ar_fire;
    int aw_fire_cyc, w_fire_cyc, ar_fire_cyc;
    bit b_cur, r_cur, b_hs, r_hs;
    int b_rise_cyc, r_rise_cyc;

    axi_lite_apb_bridge #(
        .AXI_ADDR_WIDTH(64),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .awaddr_i (awaddr),
        .awvalid_i(awvalid),
        .awready_o(awready),
        .wdata_i  (wdata),
        .wstrb_i  (wstrb),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .bresp_o  (bresp),
        .bvalid_o (bvalid),
        .bready_i (bready),
        .araddr_i (araddr),
        .arvalid_i(arvalid),
        .arready_o(arready),
        .rdata_o  (rdata),
        .rresp_o  (rresp),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .psel_o   (psel),
        .penable_o(penable),
        .pwrite_o (pwrite),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pstrb_o  (pstrb),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic issue_write(input logic [63:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int waits,
                               input bit err, input bit hang);
        apbw_t e;
        beh_t  b;
        e.addr = a[31:0];
        e.data = d;
        e.strb = s;
        b.waits = 4'(waits);
        b.err = err;
        b.hang = hang;
        b.data = $urandom;
        aw_stim.push_back(a);
        w_stim.push_back({s, d});
        exp_apw.push_back(e);
        wbeh.push_back(b);
        exp_b.push_back((err || hang) ? 2'b10 : 2'b00);
    endtask

    task automatic issue_read(input logic [63:0] a, input int waits,
                              input bit err, input bit hang,
                              input logic [31:0] d);
        beh_t b;
        b.waits = 4'(waits);
        b.err = err;
        b.hang = hang;
        b.data = d;
        ar_stim.push_back(a);
        exp_apr.push_back(a[31:0]);
        rbeh.push_back(b);
        if (hang) exp_r.push_back({2'b10, 32'hDEAD_BEEF});
        else exp_r.push_back({err ? 2'b10 : 2'b00, d});
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    function automatic bit busy();
        return aw_stim.size() != 0 || w_stim.size() != 0 ||
               ar_stim.size() != 0 || exp_b.size() != 0 ||
               exp_r.size() != 0 || exp_apw.size() != 0 ||
               exp_apr.size() != 0 || awvalid || wvalid ||
               arvalid || b_cur || r_cur;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("wait_idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    // AXI request drivers
    initial begin
        awvalid = 0; awaddr = 0; aw_fire = 0;
        forever begin
            @(negedge clk);
            if (aw_fire) begin awvalid = 0; aw_fire = 0; end
            if (!rst_n) awvalid = 0;
            else if (!awvalid && aw_stim.size() != 0 &&
                     (no_gap || $urandom_range(0, 3) != 0)) begin
                awaddr = aw_stim.pop_front();
                awvalid = 1;
            end
            aw_fire = awvalid && awready && rst_n;
            if (aw_fire) aw_fire_cyc = cyc + 1;
        end
    end

    initial begin
        wvalid = 0; wdata = 0; wstrb = 0; w_fire = 0;
        forever begin
            @(negedge clk);
            if (w_fire) begin wvalid = 0; w_fire = 0; end
            if (!rst_n) wvalid = 0;
            else if (!wvalid && w_stim.size() != 0 &&
                     (no_gap || $urandom_range(0, 3) != 0)) begin
                {wstrb, wdata} = w_stim.pop_front();
                wvalid = 1;
            end
            w_fire = wvalid && wready && rst_n;
            if (w_fire) w_fire_cyc = cyc + 1;
        end
    end

    initial begin
        arvalid = 0; araddr = 0; ar_fire = 0;
        forever begin
            @(negedge clk);
            if (ar_fire) begin arvalid = 0; ar_fire = 0; end
            if (!rst_n) arvalid = 0;
            else if (!arvalid && ar_stim.size() != 0 &&
                     (no_gap || $urandom_range(0, 3) != 0)) begin
                araddr = ar_stim.pop_front();
                arvalid = 1;
            end
            ar_fire = arvalid && arready && rst_n;
            if (ar_fire) ar_fire_cyc = cyc + 1;
        end
    end

    initial begin
        bready = 0; rready = 0;
        forever begin
            @(posedge clk);
            #1;
            bready = hold_b ? 1'b0 : ($urandom_range(0, 2) != 0);
            rready = ($urandom_range(0, 2) != 0);
        end
    end

    // APB slave model and request checker
    initial begin
        beh_t cur;
        apbw_t ew;
        bit active;
        int acc_n, exp_len;
        logic [64:0] fields;
        active = 0; acc_n = 0;
        pready = 0; pslverr = 0; prdata = 0;
        cur = '0; fields = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                pready = 0;
            end else if (psel && !penable) begin
                cur = '0;
                dir_log.push_back(pwrite);
                if (pwrite) begin
                    if (exp_apw.size() == 0) chk("unexpected_apb_wr", 1, 0);
                    else begin
                        ew = exp_apw.pop_front();
                        cur = wbeh.pop_front();
                        chk("paddr_wr", paddr, ew.addr);
                        chk("pwdata", pwdata, ew.data);
                        chk("pstrb", pstrb, ew.strb);
                    end
                end else begin
                    if (exp_apr.size() == 0) chk("unexpected_apb_rd", 1, 0);
                    else begin
                        chk("paddr_rd", paddr, exp_apr.pop_front());
                        cur = rbeh.pop_front();
                    end
                end
                fields = {pwrite, paddr, pwdata};
                active = 1;
                acc_n = 0;
                pready = 0;
            end else if (psel && penable) begin
                chk("apb_stable", {pwrite, paddr, pwdata}, fields);
                acc_n++;
                pready = !cur.hang && (acc_n == int'(cur.waits) + 1);
                pslverr = cur.err;
                prdata = cur.data;
            end else begin
                if (active) begin
                    exp_len = cur.hang ? TO : int'(cur.waits) + 1;
                    chk("access_len", acc_n, exp_len);
                    active = 0;
                end
                pready = 0;
                pslverr = $urandom_range(0, 1);
                prdata = $urandom;
            end
        end
    end

    // B channel monitor
    initial begin
        logic [1:0] bval;
        b_cur = 0; b_hs = 0; bval = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_cur = 0; b_hs = 0;
            end else begin
                if (b_hs) begin b_cur = 0; b_hs = 0; end
                if (bvalid) begin
                    chk("psel_in_bresp", psel, 0);
                    if (!b_cur) begin
                        if (exp_b.size() == 0) chk("unexpected_b", 1, 0);
                        else chk("bresp", bresp, exp_b.pop_front());
                        b_cur = 1;
                        bval = bresp;
                        b_rise_cyc = cyc;
                    end else begin
                        chk("bresp_stable", bresp, bval);
                    end
                    if (bready) b_hs = 1;
                end else if (b_cur) begin
                    chk("bvalid_dropped", 1, 0);
                    b_cur = 0;
                end
            end
        end
    end

    // R channel monitor
    initial begin
        logic [33:0] rval, e;
        r_cur = 0; r_hs = 0; rval = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_cur = 0; r_hs = 0;
            end else begin
                if (r_hs) begin r_cur = 0; r_hs = 0; end
                if (rvalid) begin
                    chk("psel_in_rresp", psel, 0);
                    if (!r_cur) begin
                        if (exp_r.size() == 0) chk("unexpected_r", 1, 0);
                        else begin
                            e = exp_r.pop_front();
                            chk("rresp", rresp, e[33:32]);
                            chk("rdata", rdata, e[31:0]);
                        end
                        r_cur = 1;
                        rval = {rresp, rdata};
                        r_rise_cyc = cyc;
                    end else begin
                        chk("r_stable", {rresp, rdata}, rval);
                    end
                    if (rready) r_hs = 1;
                end else if (r_cur) begin
                    chk("rvalid_dropped", 1, 0);
                    r_cur = 0;
                end
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got hang want done (cyc %0d)", cyc);
        total++;
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        int wf;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {psel, penable, bvalid, rvalid, awready, wready, arready,
             paddr, pwdata, pstrb, rdata, bresp, rresp, pwrite}, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        sync();
        issue_write(64'h0000_0000_1000_0000, 32'h41, 4'hF, 0, 0, 0);
        wait_idle(200);
        wf = (aw_fire_cyc > w_fire_cyc) ? aw_fire_cyc : w_fire_cyc;
        chk("wr_latency", b_rise_cyc - wf, 3);

        sync();
        issue_read(64'h0000_0000_1000_0014, 0, 0, 0, 32'h60);
        wait_idle(200);
        chk("rd_latency", r_rise_cyc - ar_fire_cyc, 3);

        dir_log.delete();
        sync();
        issue_write(64'h2000_0004, 32'hCAFE_0001, 4'h3, 0, 0, 0);
        issue_read(64'h2000_0008, 1, 0, 0, 32'h1234_5678);
        wait_idle(300);
        chk("tie1_count", dir_log.size(), 2);
        chk("tie1_first_write", dir_log[0], 1);
        chk("tie1_then_read", dir_log[1], 0);

        sync();
        issue_write(64'h2000_000C, 32'h0, 4'h0, 0, 0, 0);
        wait_idle(200);
        dir_log.delete();
        sync();
        issue_write(64'h2000_0010, 32'h5555_AAAA, 4'hC, 0, 0, 0);
        issue_read(64'h2000_0014, 0, 1, 0, 32'h0BAD_0BAD);
        wait_idle(300);
        chk("tie2_count", dir_log.size(), 2);
        chk("tie2_first_read", dir_log[0], 0);
        chk("tie2_then_write", dir_log[1], 1);

        sync();
        issue_write(64'h3000_0000, 32'h7777_7777, 4'hF, 3, 1, 0);
        wait_idle(200);

        sync();
        issue_read(64'h3000_0004, 0, 0, 1, 32'h0);
        wait_idle(300);

        hold_b = 1;
        sync();
        issue_write(64'h3000_0008, 32'h8888_0000, 4'h1, 1, 0, 0);
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        chk("bvalid_seen", bvalid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("b_held", {bvalid, psel}, 2'b10);
        end
        hold_b = 0;
        wait_idle(200);

        sync();
        issue_write(64'h4000_0000, 32'hDEAD_0000, 4'hF, 0, 0, 1);
        n = 0;
        while (!(psel && penable) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("access_reached", penable, 1);
        sync();
        rst_n = 0;
        void'(exp_b.pop_back());
        sync();
        chk("abort_outputs",
            {psel, penable, bvalid, rvalid, awready, wready, arready}, 0);
        rst_n = 1;
        repeat (20) begin
            @(negedge clk);
            chk("no_resp_after_abort", {bvalid, rvalid}, 0);
        end

        dir_log.delete();
        sync();
        issue_write(64'h4000_0010, 32'h1111_2222, 4'h5, 0, 0, 0);
        issue_read(64'h4000_0014, 2, 0, 0, 32'h3333_4444);
        wait_idle(300);
        chk("tie_after_reset_write", dir_log[0], 1);

        no_gap = 0;
        for (int i = 0; i < 200; i++) begin
            logic [63:0] a;
            int w;
            bit e, h;
            a = {$urandom, $urandom};
            w = $urandom_range(0, 4);
            e = ($urandom_range(0, 9) == 0);
            h = ($urandom_range(0, 19) == 0);
            while (aw_stim.size() + ar_stim.size() > 3) @(negedge clk);
            sync();
            if ($urandom_range(0, 1) != 0)
                issue_write(a, $urandom, 4'($urandom), w, e, h);
            else
                issue_read(a, w, e, h, $urandom);
        end
        wait_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
